// File: rtl/i2c_pkg.sv
// Shared I2C definitions: PHY bit-command encoding and the byte-level request record.
package i2c_pkg;

  localparam logic [2:0] I2C_CMD_NOP   = 3'd0;
  localparam logic [2:0] I2C_CMD_START = 3'd1;
  localparam logic [2:0] I2C_CMD_STOP  = 3'd2;
  localparam logic [2:0] I2C_CMD_WRITE = 3'd3;
  localparam logic [2:0] I2C_CMD_READ  = 3'd4;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       read;
    logic       ack;
    logic [7:0] data;
  } byte_req_t;

endpackage

// File: rtl/i2c_master_byte_ctrl.sv
// Byte-level I2C master sequencer: expands one byte request into PHY bit commands
// (optional START, 8 data bits, ACK bit, optional STOP) and returns a one-cycle response.
module i2c_master_byte_ctrl
  import i2c_pkg::*;
#(
  parameter int CMD_TIMEOUT = 1_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_start_i,
  input  logic       req_stop_i,
  input  logic       req_read_i,
  input  logic       req_ack_i,
  input  logic [7:0] req_data_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       rsp_nack_o,
  output logic       rsp_arb_lost_o,
  output logic       rsp_timeout_o,
  output logic [2:0] phy_cmd_o,
  output logic       phy_data_o,
  input  logic       phy_data_i,
  input  logic       phy_cmd_done_i,
  input  logic       phy_arb_lost_i,
  input  logic       phy_bus_busy_i,
  output logic       bus_owned_o
);

  typedef enum logic [2:0] {IDLE, WAIT_BUS, START, DATA, ACK, STOP, RESP} state_t;

  localparam int TW = (CMD_TIMEOUT < 2) ? 1 : $clog2(CMD_TIMEOUT + 1);
  localparam logic [TW-1:0] T_MAX = TW'(CMD_TIMEOUT);

  state_t          state_reg, state_next;
  logic            ready_reg, ready_next;
  logic            stop_reg, stop_next;
  logic            read_reg, read_next;
  logic            ack_reg, ack_next;
  logic [7:0]      shift_reg, shift_next;
  logic [2:0]      bit_cnt_reg, bit_cnt_next;
  logic            owned_reg, owned_next;
  logic [2:0]      cmd_reg, cmd_next;
  logic            cdata_reg, cdata_next;
  logic [TW-1:0]   tcnt_reg, tcnt_next;
  logic            nack_pend_reg, nack_pend_next;
  logic [7:0]      rsp_data_reg, rsp_data_next;
  logic            rsp_nack_reg, rsp_nack_next;
  logic            rsp_arb_reg, rsp_arb_next;
  logic            rsp_to_reg, rsp_to_next;

  byte_req_t       req_in;
  logic            eff_start;
  logic            active;

  always_comb begin
    state_next     = state_reg;
    ready_next     = 1'b0;
    stop_next      = stop_reg;
    read_next      = read_reg;
    ack_next       = ack_reg;
    shift_next     = shift_reg;
    bit_cnt_next   = bit_cnt_reg;
    owned_next     = owned_reg;
    cmd_next       = cmd_reg;
    cdata_next     = cdata_reg;
    tcnt_next      = tcnt_reg;
    nack_pend_next = nack_pend_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_nack_next  = rsp_nack_reg;
    rsp_arb_next   = rsp_arb_reg;
    rsp_to_next    = rsp_to_reg;

    req_in    = '{start: req_start_i, stop: req_stop_i, read: req_read_i,
                  ack: req_ack_i, data: req_data_i};
    eff_start = req_in.start || !owned_reg;
    active    = (state_reg != IDLE) && (state_reg != RESP);

    // Saturating stall timer; every command issue below reloads it.
    if (active && tcnt_reg != T_MAX)
      tcnt_next = tcnt_reg + TW'(1);

    if (state_reg == IDLE) begin
      if (req_valid_i && ready_reg) begin
        stop_next      = req_in.stop;
        read_next      = req_in.read;
        ack_next       = req_in.ack;
        shift_next     = req_in.data;
        bit_cnt_next   = 3'd7;
        nack_pend_next = 1'b0;
        tcnt_next      = '0;
        if (eff_start && !owned_reg && phy_bus_busy_i) begin
          state_next = WAIT_BUS;
        end else if (eff_start) begin
          state_next = START;
          cmd_next   = I2C_CMD_START;
          cdata_next = 1'b1;
        end else begin
          state_next = DATA;
          cmd_next   = req_in.read ? I2C_CMD_READ : I2C_CMD_WRITE;
          cdata_next = req_in.read | req_in.data[7];
        end
      end
    end else if (state_reg == RESP) begin
      state_next = IDLE;
    end else if (phy_arb_lost_i || tcnt_reg == T_MAX) begin
      // Abort: release the bus without a STOP; arbitration loss wins a tie.
      state_next    = RESP;
      cmd_next      = I2C_CMD_NOP;
      cdata_next    = 1'b0;
      owned_next    = 1'b0;
      rsp_data_next = read_reg ? shift_reg : 8'h00;
      rsp_nack_next = nack_pend_reg;
      rsp_arb_next  = phy_arb_lost_i;
      rsp_to_next   = !phy_arb_lost_i;
    end else begin
      case (state_reg)
        WAIT_BUS: begin
          if (!phy_bus_busy_i) begin
            state_next = START;
            cmd_next   = I2C_CMD_START;
            cdata_next = 1'b1;
            tcnt_next  = '0;
          end
        end
        START: begin
          if (phy_cmd_done_i) begin
            owned_next = 1'b1;
            cmd_next   = I2C_CMD_NOP;
            state_next = DATA;
          end
        end
        DATA: begin
          if (cmd_reg == I2C_CMD_NOP) begin
            cmd_next   = read_reg ? I2C_CMD_READ : I2C_CMD_WRITE;
            cdata_next = read_reg | shift_reg[7];
            tcnt_next  = '0;
          end else if (phy_cmd_done_i) begin
            shift_next = {shift_reg[6:0], phy_data_i};
            cmd_next   = I2C_CMD_NOP;
            if (bit_cnt_reg == 3'd0)
              state_next = ACK;
            else
              bit_cnt_next = bit_cnt_reg - 3'd1;
          end
        end
        ACK: begin
          if (cmd_reg == I2C_CMD_NOP) begin
            cmd_next   = read_reg ? I2C_CMD_WRITE : I2C_CMD_READ;
            cdata_next = read_reg ? ~ack_reg : 1'b1;
            tcnt_next  = '0;
          end else if (phy_cmd_done_i) begin
            cmd_next       = I2C_CMD_NOP;
            nack_pend_next = !read_reg && phy_data_i;
            if (stop_reg) begin
              state_next = STOP;
            end else begin
              state_next    = RESP;
              rsp_data_next = read_reg ? shift_reg : 8'h00;
              rsp_nack_next = !read_reg && phy_data_i;
              rsp_arb_next  = 1'b0;
              rsp_to_next   = 1'b0;
            end
          end
        end
        STOP: begin
          if (cmd_reg == I2C_CMD_NOP) begin
            cmd_next   = I2C_CMD_STOP;
            cdata_next = 1'b1;
            tcnt_next  = '0;
          end else if (phy_cmd_done_i) begin
            cmd_next      = I2C_CMD_NOP;
            owned_next    = 1'b0;
            state_next    = RESP;
            rsp_data_next = read_reg ? shift_reg : 8'h00;
            rsp_nack_next = nack_pend_reg;
            rsp_arb_next  = 1'b0;
            rsp_to_next   = 1'b0;
          end
        end
        default: ;
      endcase
    end

    ready_next = (state_next == IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg     <= IDLE;
      ready_reg     <= 1'b0;
      stop_reg      <= 1'b0;
      read_reg      <= 1'b0;
      ack_reg       <= 1'b0;
      shift_reg     <= 8'h00;
      bit_cnt_reg   <= 3'd0;
      owned_reg     <= 1'b0;
      cmd_reg       <= I2C_CMD_NOP;
      cdata_reg     <= 1'b0;
      tcnt_reg      <= '0;
      nack_pend_reg <= 1'b0;
      rsp_data_reg  <= 8'h00;
      rsp_nack_reg  <= 1'b0;
      rsp_arb_reg   <= 1'b0;
      rsp_to_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ready_reg     <= ready_next;
      stop_reg      <= stop_next;
      read_reg      <= read_next;
      ack_reg       <= ack_next;
      shift_reg     <= shift_next;
      bit_cnt_reg   <= bit_cnt_next;
      owned_reg     <= owned_next;
      cmd_reg       <= cmd_next;
      cdata_reg     <= cdata_next;
      tcnt_reg      <= tcnt_next;
      nack_pend_reg <= nack_pend_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_nack_reg  <= rsp_nack_next;
      rsp_arb_reg   <= rsp_arb_next;
      rsp_to_reg    <= rsp_to_next;
    end
  end

  assign req_ready_o    = ready_reg;
  assign rsp_valid_o    = (state_reg == RESP);
  assign rsp_data_o     = rsp_data_reg;
  assign rsp_nack_o     = rsp_nack_reg;
  assign rsp_arb_lost_o = rsp_arb_reg;
  assign rsp_timeout_o  = rsp_to_reg;
  assign phy_cmd_o      = cmd_reg;
  assign phy_data_o     = cdata_reg;
  assign bus_owned_o    = owned_reg;

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Bench for i2c_master_byte_ctrl: a behavioural PHY responder plus a transaction-level
// model of the expected bit-command list and response for each byte request.
module tb_i2c_master_byte_ctrl;
  import i2c_pkg::*;

  localparam int TMO = 256;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  logic       req_start_i = 1'b0;
  logic       req_stop_i = 1'b0;
  logic       req_read_i = 1'b0;
  logic       req_ack_i = 1'b0;
  logic [7:0] req_data_i = 8'h00;
  logic       rsp_valid_o;
  logic [7:0] rsp_data_o;
  logic       rsp_nack_o;
  logic       rsp_arb_lost_o;
  logic       rsp_timeout_o;
  logic [2:0] phy_cmd_o;
  logic       phy_data_o;
  logic       phy_data_i = 1'b0;
  logic       phy_cmd_done_i = 1'b0;
  logic       phy_arb_lost_i = 1'b0;
  logic       phy_bus_busy_i = 1'b0;
  logic       bus_owned_o;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_txn = 0;
  bit         model_owned = 1'b0;
  logic [3:0] log_q[$];

  always #5 clk = ~clk;

  i2c_master_byte_ctrl #(.CMD_TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_start_i(req_start_i), .req_stop_i(req_stop_i), .req_read_i(req_read_i),
    .req_ack_i(req_ack_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_nack_o(rsp_nack_o),
    .rsp_arb_lost_o(rsp_arb_lost_o), .rsp_timeout_o(rsp_timeout_o),
    .phy_cmd_o(phy_cmd_o), .phy_data_o(phy_data_o), .phy_data_i(phy_data_i),
    .phy_cmd_done_i(phy_cmd_done_i), .phy_arb_lost_i(phy_arb_lost_i),
    .phy_bus_busy_i(phy_bus_busy_i), .bus_owned_o(bus_owned_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, req_ready_o, 0);
    check({tag, "_rspv"},  rsp_valid_o, 0);
    check({tag, "_cmd"},   phy_cmd_o, I2C_CMD_NOP);
    check({tag, "_pdata"}, phy_data_o, 0);
    check({tag, "_owned"}, bus_owned_o, 0);
    check({tag, "_rsp"},   {rsp_data_o, rsp_nack_o, rsp_arb_lost_o, rsp_timeout_o}, 0);
  endtask

  // arb_at: index of the command during which arbitration is lost (-1: never).
  // hang: PHY never completes a command. busy_len: cycles bus stays busy after accept.
  task automatic run_txn(input bit start, input bit stop, input bit read, input bit ack,
                         input logic [7:0] data, input logic [7:0] rd_bits, input bit snack,
                         input int arb_at, input bit hang, input int busy_len);
    logic [3:0] exp_q[$];
    logic [7:0] rb;
    logic [2:0] cur_cmd;
    logic       cur_dat;
    bit         eff, pend, gap, got, aborted;
    int         cnt, rd_idx, ncmd, it, done_it, arb_it, drop_it, first_it, rsp_it, hold_err, exp_len;
    logic [7:0] r_data;
    logic       r_nack, r_arb, r_to;

    rb = rd_bits;
    eff = start || !model_owned;
    if (eff) exp_q.push_back({I2C_CMD_START, 1'b0});
    for (int i = 7; i >= 0; i--)
      exp_q.push_back(read ? {I2C_CMD_READ, 1'b0} : {I2C_CMD_WRITE, data[i]});
    exp_q.push_back(read ? {I2C_CMD_WRITE, ~ack} : {I2C_CMD_READ, 1'b0});
    if (stop) exp_q.push_back({I2C_CMD_STOP, 1'b0});
    aborted = (arb_at >= 0) || hang;
    exp_len = (arb_at >= 0) ? arb_at + 1 : (hang ? 1 : exp_q.size());

    log_q.delete();
    @(negedge clk);
    phy_bus_busy_i = (busy_len > 0);
    it = 0;
    while (!req_ready_o && it < 20) begin
      @(negedge clk);
      it++;
    end
    check("ready", req_ready_o, 1);
    req_start_i = start; req_stop_i = stop; req_read_i = read;
    req_ack_i = ack; req_data_i = data; req_valid_i = 1'b1;
    @(posedge clk);

    pend = 0; gap = 0; got = 0; cnt = 0; rd_idx = 0; ncmd = 0; hold_err = 0;
    done_it = -1; arb_it = -1; drop_it = -1; first_it = -1; rsp_it = -1;
    cur_cmd = I2C_CMD_NOP; cur_dat = 1'b0;
    r_data = 0; r_nack = 0; r_arb = 0; r_to = 0;
    for (it = 0; it < 3000 && !got; it++) begin
      @(negedge clk);
      req_valid_i = 1'b0; phy_cmd_done_i = 1'b0; phy_arb_lost_i = 1'b0;
      if (busy_len > 0 && it == busy_len) begin
        phy_bus_busy_i = 1'b0;
        drop_it = it;
      end
      if (gap) begin
        check("nop_gap", phy_cmd_o, I2C_CMD_NOP);
        gap = 0;
      end
      if (rsp_valid_o) begin
        got = 1; rsp_it = it;
        r_data = rsp_data_o; r_nack = rsp_nack_o; r_arb = rsp_arb_lost_o; r_to = rsp_timeout_o;
      end else begin
        if (pend) begin
          if (phy_cmd_o !== cur_cmd || phy_data_o !== cur_dat) hold_err++;
        end else if (phy_cmd_o != I2C_CMD_NOP) begin
          cur_cmd = phy_cmd_o; cur_dat = phy_data_o;
          log_q.push_back({phy_cmd_o, (phy_cmd_o == I2C_CMD_WRITE) ? phy_data_o : 1'b0});
          if (first_it < 0) first_it = it;
          pend = 1;
          cnt = hang ? -1 : int'($urandom_range(0, 3));
          if (ncmd == arb_at) begin
            phy_arb_lost_i = 1'b1; arb_it = it; pend = 0; gap = 1;
          end
          ncmd++;
        end
        if (pend && cnt == 0) begin
          if (cur_cmd == I2C_CMD_READ) begin
            if (read && rd_idx < 8) begin
              phy_data_i = rb[7 - rd_idx];
              rd_idx++;
            end else begin
              phy_data_i = snack;
            end
          end
          phy_cmd_done_i = 1'b1; pend = 0; gap = 1; done_it = it;
        end else if (pend && cnt > 0) begin
          cnt--;
        end
      end
    end

    n_txn++;
    check("rsp_seen", got, 1);
    if (got) begin
      check("ncmd", log_q.size(), exp_len);
      for (int i = 0; i < exp_len && i < log_q.size(); i++)
        check($sformatf("cmd%0d", i), log_q[i], exp_q[i]);
      check("hold", hold_err, 0);
      if (busy_len > 0) check("wait_bus_issue", first_it, drop_it + 1);
      else              check("first_issue", first_it, 0);
      if (arb_at >= 0)  check("rsp_time", rsp_it, arb_it + 1);
      else if (hang)    check("rsp_time", rsp_it, first_it + TMO + 1);
      else              check("rsp_time", rsp_it, done_it + 1);
      check("rsp_arb", r_arb, (arb_at >= 0));
      check("rsp_to", r_to, hang && arb_at < 0);
      if (!aborted) begin
        check("rsp_data", r_data, read ? rd_bits : 8'h00);
        check("rsp_nack", r_nack, !read && snack);
      end
      model_owned = aborted ? 1'b0 : !stop;
      check("owned", bus_owned_o, model_owned);
      @(negedge clk);
      check("rsp_pulse", rsp_valid_o, 0);
      check("ready_back", req_ready_o, 1);
    end
    $display("txn %0d: start=%0b stop=%0b read=%0b ack=%0b data=%02h -> cmds=%0d rsp data=%02h nack=%0b arb=%0b to=%0b owned=%0b",
             n_txn, start, stop, read, ack, data, log_q.size(), r_data, r_nack, r_arb, r_to, bus_owned_o);
  endtask

  initial begin
    int seen;
    logic [2:0] prev_cmd;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_i = 1'b1;
    @(negedge clk);
    check("ready_after_release", req_ready_o, 1);

    // Directed cases
    run_txn(1, 1, 0, 0, 8'hA5, 8'h00, 0, -1, 0, 0);
    run_txn(1, 1, 1, 0, 8'h00, 8'h3C, 0, -1, 0, 0);
    run_txn(1, 0, 0, 0, 8'h5A, 8'h00, 0, -1, 0, 0);
    run_txn(0, 0, 0, 0, 8'h00, 8'h00, 1, -1, 0, 0);
    run_txn(1, 1, 0, 0, 8'hC3, 8'h00, 0, 4, 0, 0);
    run_txn(1, 1, 0, 0, 8'h81, 8'h00, 0, -1, 0, 200);
    run_txn(1, 1, 0, 0, 8'h7E, 8'h00, 0, -1, 1, 0);

    // Randomised cases
    for (int n = 0; n < 24; n++) begin
      run_txn($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), 8'($urandom), 8'($urandom), $urandom_range(0, 1),
              -1, 0, 0);
    end

    // Reset in the middle of a byte: simple responder, then pull reset
    @(negedge clk);
    req_start_i = 1; req_stop_i = 1; req_read_i = 0; req_ack_i = 0;
    req_data_i = 8'hF0; req_valid_i = 1;
    prev_cmd = I2C_CMD_NOP;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      req_valid_i = 0;
      phy_cmd_done_i = (phy_cmd_o != I2C_CMD_NOP) && (prev_cmd == I2C_CMD_NOP);
      prev_cmd = phy_cmd_done_i ? phy_cmd_o : I2C_CMD_NOP;
    end
    check("mid_byte_busy", phy_cmd_o == I2C_CMD_WRITE || phy_cmd_o == I2C_CMD_NOP, 1);
    rst_i = 1'b0;
    phy_cmd_done_i = 0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_i = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid_o) seen++;
    end
    check("midrst_no_rsp", seen, 0);
    check("midrst_ready", req_ready_o, 1);
    model_owned = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
